lab3_decoder_scan: RTL and testbench



---
 rtl/lab3_decoder_scan_if.sv | 25 ++
 rtl/lab3_decoder_scan.sv | 93 +++++++++
 tb/tb_lab3_decoder_scan.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/lab3_decoder_scan_if.sv
// Decoder/scan bus: control inputs and registered one-hot outputs.
interface lab3_decoder_scan_if #(
  parameter int SEL_W = 5
);
  localparam int N = 1 << SEL_W;

  logic             enable;
  logic             mode;
  logic [SEL_W-1:0] sel;
  logic             load;
  logic [SEL_W-1:0] limit;
  logic [N-1:0]     dout;
  logic [SEL_W-1:0] index;
  logic             wrap;

  modport master (
    output enable, mode, sel, load, limit,
    input  dout, index, wrap
  );

  modport slave (
    input  enable, mode, sel, load, limit,
    output dout, index, wrap
  );
endinterface

// File: rtl/lab3_decoder_scan.sv
// Registered one-hot decoder with direct and auto-scan modes.
// DECODER_ACTIVE_LOW_EN: dout is driven active-low (idle/reset all-ones).
module lab3_decoder_scan #(
  parameter int SEL_W = 5,
  parameter int DWELL = 4
) (
  input  logic                clk,
  input  logic                rst,
  lab3_decoder_scan_if.slave  bus
);
  localparam int N  = 1 << SEL_W;
  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DWELL - 1);
  localparam logic [N-1:0]  ONE     = N'(1);

  typedef enum logic [1:0] {
    IDLE,
    DIRECT,
    SCAN
  } state_e;

  state_e           state_q, state_d;
  logic [SEL_W-1:0] index_q, index_d;
  logic [N-1:0]     dout_q, dout_d;
  logic             wrap_q, wrap_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      index_q <= '0;
      dout_q  <= '0;
      wrap_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      dout_q  <= dout_d;
      wrap_q  <= wrap_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = IDLE;
    index_d = index_q;
    dout_d  = '0;
    wrap_d  = 1'b0;
    cnt_d   = '0;

    unique case (1'b1)
      !bus.enable:             state_d = IDLE;
      bus.enable && !bus.mode: state_d = DIRECT;
      bus.enable && bus.mode:  state_d = SCAN;
      default:                 state_d = IDLE;
    endcase

    unique case (state_d)
      DIRECT: begin
        index_d = bus.sel;
        dout_d  = ONE << bus.sel;
      end
      SCAN: begin
        // Entry cycle starts a fresh dwell on the held index
        if (bus.load) begin
          index_d = bus.sel;
        end else if (state_q != SCAN) begin
          index_d = index_q;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end else if (index_q >= bus.limit) begin
          index_d = '0;
          wrap_d  = 1'b1;
        end else begin
          index_d = index_q + 1'b1;
        end
        dout_d = ONE << index_d;
      end
      default: begin
        dout_d = '0;
      end
    endcase
  end

  assign bus.index = index_q;
  assign bus.wrap  = wrap_q;
`ifdef DECODER_ACTIVE_LOW_EN
  assign bus.dout  = ~dout_q;
`else
  assign bus.dout  = dout_q;
`endif

endmodule

// File: tb/tb_lab3_decoder_scan.sv
// Scoreboard bench: driver pushes model predictions, monitor compares.
module tb_lab3_decoder_scan;
  localparam int SEL_W = 5;
  localparam int DWELL = 4;
  localparam int N     = 1 << SEL_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lab3_decoder_scan_if #(.SEL_W(SEL_W)) bus ();

  lab3_decoder_scan #(
    .SEL_W(SEL_W),
    .DWELL(DWELL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [N-1:0]     dout;
    logic [SEL_W-1:0] idx;
    logic             wrap;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  int m_idx, m_cnt;
  bit m_on, m_wrap, m_scan;

  function automatic exp_t expv();
    exp_t e;
    logic [63:0] oh;
    oh = m_on ? (64'd1 << m_idx) : 64'd0;
    e.dout = oh[N-1:0];
`ifdef DECODER_ACTIVE_LOW_EN
    e.dout = ~e.dout;
`endif
    e.idx  = m_idx[SEL_W-1:0];
    e.wrap = m_wrap;
    return e;
  endfunction

  function automatic void model_reset();
    m_idx  = 0;
    m_cnt  = 0;
    m_on   = 0;
    m_wrap = 0;
    m_scan = 0;
  endfunction

  function automatic void model_step();
    m_wrap = 0;
    if (!bus.enable) begin
      m_on = 0; m_cnt = 0; m_scan = 0;
    end else if (!bus.mode) begin
      m_idx = int'(bus.sel);
      m_on = 1; m_cnt = 0; m_scan = 0;
    end else begin
      m_on = 1;
      if (bus.load) begin
        m_idx = int'(bus.sel); m_cnt = 0;
      end else if (!m_scan) begin
        m_cnt = 0;
      end else if (m_cnt < DWELL - 1) begin
        m_cnt++;
      end else begin
        m_cnt = 0;
        if (m_idx >= int'(bus.limit)) begin
          m_idx = 0; m_wrap = 1;
        end else begin
          m_idx++;
        end
      end
      m_scan = 1;
    end
  endfunction

  task automatic cmp(string nm, exp_t e);
    checks++;
    if (bus.dout !== e.dout || bus.index !== e.idx || bus.wrap !== e.wrap) begin
      errors++;
      $display("FAIL %s t=%0t got dout=%h idx=%0d wrap=%0b want dout=%h idx=%0d wrap=%0b",
               nm, $time, bus.dout, bus.index, bus.wrap, e.dout, e.idx, e.wrap);
    end
  endtask

  task automatic drive(bit en, bit md, bit ld, int s, int lim);
    @(negedge clk);
    rst = 1'b0;
    bus.enable = en;
    bus.mode   = md;
    bus.load   = ld;
    bus.sel    = s[SEL_W-1:0];
    bus.limit  = lim[SEL_W-1:0];
    model_step();
    q.push_back(expv());
  endtask

  task automatic async_reset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    cmp("async_rst", expv());
    q.push_back(expv());
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) cmp("cycle", q.pop_front());
    end
  end

  initial begin
    bus.enable = 1'b0;
    bus.mode   = 1'b0;
    bus.load   = 1'b0;
    bus.sel    = '0;
    bus.limit  = '0;
    model_reset();
    #1;
    cmp("reset", expv());
    @(negedge clk);
    q.push_back(expv());

    for (int s = 0; s < N; s++) drive(1, 0, 0, s, 0);
    repeat (2) drive(0, 0, 0, 0, 0);

    drive(1, 0, 0, 0, 3);
    repeat (36) drive(1, 1, 0, 0, 3);

    drive(1, 1, 1, 0, 31);
    repeat (3) drive(1, 1, 0, 0, 31);
    drive(1, 1, 1, 10, 31);
    repeat (6) drive(1, 1, 0, 0, 31);

    drive(1, 1, 1, 7, 31);
    repeat (2) drive(1, 1, 0, 0, 31);
    repeat (14) drive(1, 1, 0, 0, 2);

    drive(1, 1, 1, 5, 31);
    drive(1, 1, 0, 0, 31);
    async_reset();
    repeat (10) drive(1, 1, 0, 0, 31);

    drive(1, 1, 0, 0, 0);
    repeat (9) drive(1, 1, 0, 0, 0);

    for (int i = 0; i < 800; i++) begin
      drive($urandom_range(0, 15) != 0,
            $urandom_range(0, 3) != 0,
            $urandom_range(0, 11) == 0,
            int'($urandom_range(0, N - 1)),
            ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3))
                                        : int'($urandom_range(4, N - 1)));
      if ($urandom_range(0, 199) == 0) async_reset();
    end

    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
